// File: rtl/step_clk_gen.sv
`default_nettype none
// ============================================================================
// Module      : step_clk_gen
// Description : Debounced single-step / free-run clock source for a CPU core.
//               Macro STEP_COUNT_EN enables the step_count counter.
// Revision    : 1.0 - initial release
// ============================================================================
module step_clk_gen #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int STEP_HIGH_CYCLES = 4,
    parameter int RUN_HALF_PERIOD  = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn,
    input  logic        run_mode,
    output logic        step_clk,
    output logic [15:0] step_count,
    output logic        busy
);

    localparam int c_DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int c_PH_MAX = (STEP_HIGH_CYCLES > RUN_HALF_PERIOD) ? STEP_HIGH_CYCLES
                                                                   : RUN_HALF_PERIOD;
    localparam int c_PH_W   = (c_PH_MAX > 1) ? $clog2(c_PH_MAX) : 1;

    localparam logic [c_DB_W-1:0] c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DB_W-1:0] c_DB_ONE    = c_DB_W'(1);
    localparam logic [c_PH_W-1:0] c_STEP_LAST = c_PH_W'(STEP_HIGH_CYCLES - 1);
    localparam logic [c_PH_W-1:0] c_RUN_LAST  = c_PH_W'(RUN_HALF_PERIOD - 1);
    localparam logic [c_PH_W-1:0] c_PH_ONE    = c_PH_W'(1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_STEP_HI = 3'd1;
    localparam logic [2:0] c_ST_STEP_LO = 3'd2;
    localparam logic [2:0] c_ST_RUN_HI  = 3'd3;
    localparam logic [2:0] c_ST_RUN_LO  = 3'd4;

    logic [1:0]        r_sync;
    logic              r_db;
    logic              r_db_d;
    logic              r_press;
    logic [c_DB_W-1:0] r_db_cnt;
    logic [2:0]        r_state;
    logic [c_PH_W-1:0] r_ph_cnt;
    logic              r_step_clk;
    logic              r_busy;
    logic [2:0]        w_next_state;
    logic              w_phase_done;

    // Press pulse is registered, so it lags the debounced rising edge by one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync   <= 2'b00;
            r_db     <= 1'b0;
            r_db_d   <= 1'b0;
            r_press  <= 1'b0;
            r_db_cnt <= '0;
        end else begin
            r_sync  <= {r_sync[0], btn};
            r_db_d  <= r_db;
            r_press <= r_db & ~r_db_d;
            if (r_sync[1] == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_db     <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_ONE;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_phase_done = 1'b0;
        case (r_state)
            c_ST_STEP_HI, c_ST_STEP_LO: w_phase_done = (r_ph_cnt == c_STEP_LAST);
            c_ST_RUN_HI,  c_ST_RUN_LO:  w_phase_done = (r_ph_cnt == c_RUN_LAST);
            default:                    w_phase_done = 1'b0;
        endcase
        case (r_state)
            c_ST_IDLE: begin
                if (run_mode)     w_next_state = c_ST_RUN_HI;
                else if (r_press) w_next_state = c_ST_STEP_HI;
            end
            c_ST_STEP_HI: if (w_phase_done) w_next_state = c_ST_STEP_LO;
            c_ST_STEP_LO: if (w_phase_done) w_next_state = c_ST_IDLE;
            c_ST_RUN_HI:  if (w_phase_done) w_next_state = c_ST_RUN_LO;
            c_ST_RUN_LO: begin
                if (w_phase_done) w_next_state = run_mode ? c_ST_RUN_HI : c_ST_IDLE;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // Outputs decode the next state so they change on the same edge as the state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_ST_IDLE;
            r_ph_cnt   <= '0;
            r_step_clk <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_step_clk <= (w_next_state == c_ST_STEP_HI) || (w_next_state == c_ST_RUN_HI);
            r_busy     <= (w_next_state != c_ST_IDLE);
            if ((w_next_state != r_state) || (w_next_state == c_ST_IDLE)) begin
                r_ph_cnt <= '0;
            end else begin
                r_ph_cnt <= r_ph_cnt + c_PH_ONE;
            end
        end
    end

    assign step_clk = r_step_clk;
    assign busy     = r_busy;

`ifdef STEP_COUNT_EN
    logic [15:0] r_step_count;
    logic        w_enter_high;

    assign w_enter_high = (w_next_state != r_state) &&
                          ((w_next_state == c_ST_STEP_HI) || (w_next_state == c_ST_RUN_HI));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_step_count <= 16'h0000;
        end else if (w_enter_high) begin
            r_step_count <= r_step_count + 16'h0001;
        end
    end

    assign step_count = r_step_count;
`else
    assign step_count = 16'h0000;
`endif

endmodule
`default_nettype wire
